// File: rtl/mips_mc_controller_if.sv
// Memory-side handshake between the multicycle controller and the memory
// subsystem.
//   master (controller): drives memreq/memwrite/iord/readcontrol/writecontrol,
//                        samples mem_ready.
//   slave  (memory)    : the mirror image.
// Signal meanings:
//   memreq       access request for the current cycle
//   memwrite     request is a store
//   iord         address select: 0 = PC, 1 = ALUOut
//   readcontrol  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu
//   writecontrol 00 sw, 01 sh, 10 sb
//   mem_ready    memory accepted/completed the current access
interface mips_mc_controller_if;
  logic       mem_ready;
  logic       memreq;
  logic       memwrite;
  logic       iord;
  logic [2:0] readcontrol;
  logic [1:0] writecontrol;

  modport master (
    input  mem_ready,
    output memreq, memwrite, iord, readcontrol, writecontrol
  );

  modport slave (
    output mem_ready,
    input  memreq, memwrite, iord, readcontrol, writecontrol
  );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS controller: one FSM sequences fetch, decode, execute,
// memory and writeback, driving every datapath and memory control line
// combinationally from the registered state (plus op/funct where the state
// needs them). Memory accesses wait on mem_ready with a bounded wait; illegal
// opcodes/functs and memory timeouts land in an absorbing FAULT state.
// Ports:
//   clk, reset (async, active low), start (leave IDLE)
//   op, funct      instruction fields from the instruction register
//   zero           ALU zero flag (consumed by the datapath PC-enable logic)
//   mem            memory handshake (master side)
//   irwrite, pcwrite, branch, branch_ne, regwrite, regdst, memtoreg,
//   alusrca, alusrcb, signext, shamtsrc, pcsrc, alucontrol  datapath controls
//   fault          sticky fault flag; state_dbg current state encoding
module mips_mc_controller #(
  parameter int unsigned ALUCTRL_W      = 5,
  parameter int unsigned MEM_TIMEOUT    = 16,
  parameter bit          RESET_TO_FETCH = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic                  zero,
  mips_mc_controller_if.master  mem,
  output logic                  irwrite,
  output logic                  pcwrite,
  output logic                  branch,
  output logic                  branch_ne,
  output logic                  regwrite,
  output logic [1:0]            regdst,
  output logic [1:0]            memtoreg,
  output logic                  alusrca,
  output logic [1:0]            alusrcb,
  output logic                  signext,
  output logic                  shamtsrc,
  output logic [1:0]            pcsrc,
  output logic [ALUCTRL_W-1:0]  alucontrol,
  output logic                  fault,
  output logic [3:0]            state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_EXECI, S_ALUIWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_FAULT
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
    ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11
  } alu_e;

  state_e     state, state_n, ctl_state;
  logic [7:0] wait_cnt, wait_cnt_n;
  logic       timeout;
  alu_e       alu, r_alu, i_alu;
  logic       r_ok, r_shift, i_ok, i_zext, is_load, is_store;
  logic [2:0] rd_ctl;
  logic [1:0] wr_ctl;
  logic       unused_zero;

  assign unused_zero = zero;
  assign state_dbg   = state;

  // Outputs are decoded from IDLE while reset is low, so an access in flight
  // drops memreq (and any write strobe) the instant reset asserts.
  assign ctl_state = reset ? state : S_IDLE;

  // The MEM_TIMEOUT-th consecutive not-ready cycle faults unless mem_ready
  // arrives in that same cycle.
  assign timeout = !mem.mem_ready && (wait_cnt == 8'(MEM_TIMEOUT - 1));

  // R-type funct decode
  always_comb begin
    r_ok    = 1'b1;
    r_shift = 1'b0;
    r_alu   = ALU_ADD;
    case (funct)
      6'h00:        begin r_alu = ALU_SLL; r_shift = 1'b1; end
      6'h02:        begin r_alu = ALU_SRL; r_shift = 1'b1; end
      6'h03:        begin r_alu = ALU_SRA; r_shift = 1'b1; end
      6'h08:        r_alu = ALU_ADD;
      6'h20, 6'h21: r_alu = ALU_ADD;
      6'h22, 6'h23: r_alu = ALU_SUB;
      6'h24:        r_alu = ALU_AND;
      6'h25:        r_alu = ALU_OR;
      6'h26:        r_alu = ALU_XOR;
      6'h27:        r_alu = ALU_NOR;
      6'h2A:        r_alu = ALU_SLT;
      6'h2B:        r_alu = ALU_SLTU;
      default:      r_ok = 1'b0;
    endcase
  end

  // I-type ALU and load/store decode
  always_comb begin
    i_ok     = 1'b1;
    i_zext   = 1'b0;
    i_alu    = ALU_ADD;
    is_load  = 1'b0;
    is_store = 1'b0;
    rd_ctl   = 3'b000;
    wr_ctl   = 2'b00;
    case (op)
      6'h08:   i_alu = ALU_ADD;
      6'h0A:   i_alu = ALU_SLT;
      6'h0B:   i_alu = ALU_SLTU;
      6'h0C:   begin i_alu = ALU_AND; i_zext = 1'b1; end
      6'h0D:   begin i_alu = ALU_OR;  i_zext = 1'b1; end
      6'h0E:   begin i_alu = ALU_XOR; i_zext = 1'b1; end
      6'h0F:   begin i_alu = ALU_LUI; i_zext = 1'b1; end
      default: i_ok = 1'b0;
    endcase
    case (op)
      6'h23:   begin is_load = 1'b1;  rd_ctl = 3'b000; end
      6'h21:   begin is_load = 1'b1;  rd_ctl = 3'b001; end
      6'h25:   begin is_load = 1'b1;  rd_ctl = 3'b010; end
      6'h20:   begin is_load = 1'b1;  rd_ctl = 3'b011; end
      6'h24:   begin is_load = 1'b1;  rd_ctl = 3'b100; end
      6'h2B:   begin is_store = 1'b1; wr_ctl = 2'b00;  end
      6'h29:   begin is_store = 1'b1; wr_ctl = 2'b01;  end
      6'h28:   begin is_store = 1'b1; wr_ctl = 2'b10;  end
      default: ;
    endcase
  end

  // Next state and control outputs
  always_comb begin
    state_n          = state;
    mem.memreq       = 1'b0;
    mem.memwrite     = 1'b0;
    mem.iord         = 1'b0;
    mem.readcontrol  = '0;
    mem.writecontrol = '0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    regwrite  = 1'b0;
    regdst    = '0;
    memtoreg  = '0;
    alusrca   = 1'b0;
    alusrcb   = '0;
    signext   = 1'b0;
    shamtsrc  = 1'b0;
    pcsrc     = '0;
    alu       = ALU_ADD;
    fault     = 1'b0;
    case (ctl_state)
      S_IDLE: if (start) state_n = S_FETCH;
      S_FETCH: begin
        mem.memreq = 1'b1;
        alusrcb    = 2'b01;
        if (mem.mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_n = S_DECODE;
        end else if (timeout) begin
          state_n = S_FAULT;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        signext = 1'b1;
        if (is_load || is_store)                      state_n = S_MEMADR;
        else if (op == 6'h00 && !r_ok)                state_n = S_FAULT;
        else if (op == 6'h00 && funct == 6'h08)       state_n = S_JR;
        else if (op == 6'h00)                         state_n = S_EXEC;
        else if (i_ok)                                state_n = S_EXECI;
        else if (op == 6'h04 || op == 6'h05)          state_n = S_BRANCH;
        else if (op == 6'h02)                         state_n = S_JUMP;
        else if (op == 6'h03)                         state_n = S_JAL;
        else                                          state_n = S_FAULT;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        signext = 1'b1;
        if (is_load) state_n = S_MEMRD;
        else         state_n = S_MEMWR;
      end
      S_MEMRD: begin
        mem.memreq      = 1'b1;
        mem.iord        = 1'b1;
        mem.readcontrol = rd_ctl;
        if (mem.mem_ready) state_n = S_MEMWB;
        else if (timeout)  state_n = S_FAULT;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 2'b01;
        state_n  = S_FETCH;
      end
      S_MEMWR: begin
        mem.memreq       = 1'b1;
        mem.memwrite     = 1'b1;
        mem.iord         = 1'b1;
        mem.writecontrol = wr_ctl;
        if (mem.mem_ready) state_n = S_FETCH;
        else if (timeout)  state_n = S_FAULT;
      end
      S_EXEC: begin
        alusrca  = 1'b1;
        alu      = r_alu;
        shamtsrc = r_shift;
        state_n  = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 2'b01;
        state_n  = S_FETCH;
      end
      S_EXECI: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        signext = !i_zext;
        alu     = i_alu;
        state_n = S_ALUIWB;
      end
      S_ALUIWB: begin
        regwrite = 1'b1;
        state_n  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca   = 1'b1;
        alu       = ALU_SUB;
        branch    = 1'b1;
        branch_ne = (op == 6'h05);
        pcsrc     = 2'b01;
        state_n   = S_FETCH;
      end
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        state_n = S_FETCH;
      end
      S_JAL: begin
        pcwrite  = 1'b1;
        pcsrc    = 2'b10;
        regwrite = 1'b1;
        regdst   = 2'b10;
        memtoreg = 2'b10;
        state_n  = S_FETCH;
      end
      S_JR: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b11;
        state_n = S_FETCH;
      end
      S_FAULT: fault = 1'b1;
      default: state_n = S_FAULT;
    endcase
    alucontrol = ALUCTRL_W'(alu);
  end

  // Wait counter restarts on entry to a wait state and whenever mem_ready is seen.
  always_comb begin
    wait_cnt_n = '0;
    if ((state inside {S_FETCH, S_MEMRD, S_MEMWR}) && !mem.mem_ready && state_n == state)
      wait_cnt_n = wait_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RESET_TO_FETCH ? S_FETCH : S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
    end
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller. Each stimulus step drives one cycle
// of inputs and queues the full expected control vector for that cycle; a
// separate monitor pops and compares on the falling edge.
module tb_mips_mc_controller;

  localparam logic [3:0] ST_FETCH  = 4'd1,  ST_DECODE = 4'd2,  ST_MEMADR = 4'd3,
                         ST_MEMRD  = 4'd4,  ST_MEMWB  = 4'd5,  ST_MEMWR  = 4'd6,
                         ST_EXEC   = 4'd7,  ST_ALUWB  = 4'd8,  ST_EXECI  = 4'd9,
                         ST_ALUIWB = 4'd10, ST_BRANCH = 4'd11, ST_JAL    = 4'd13,
                         ST_JR     = 4'd14, ST_FAULT  = 4'd15;

  typedef struct packed {
    logic [3:0] st;
    logic       fault, memreq, memwrite, iord, irwrite, pcwrite, branch, branch_ne, regwrite;
    logic [1:0] regdst, memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       signext, shamtsrc;
    logic [1:0] pcsrc;
    logic [4:0] alu;
    logic [2:0] rc;
    logic [1:0] wc;
  } ctl_t;

  typedef struct {
    int unsigned cyc;
    string       name;
    ctl_t        exp;
  } sb_t;

  logic clk = 1'b0;
  logic reset, start, zero;
  logic [5:0] op, funct;
  logic irwrite, pcwrite, branch, branch_ne, regwrite, alusrca, signext, shamtsrc, fault;
  logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
  logic [4:0] alucontrol;
  logic [3:0] state_dbg;
  ctl_t act;

  sb_t sb[$];
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  mips_mc_controller_if mif ();

  mips_mc_controller #(.ALUCTRL_W(5), .MEM_TIMEOUT(16), .RESET_TO_FETCH(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .funct(funct), .zero(zero),
    .mem(mif.master), .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
    .branch_ne(branch_ne), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .signext(signext), .shamtsrc(shamtsrc),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign act = {state_dbg, fault, mif.memreq, mif.memwrite, mif.iord, irwrite, pcwrite,
                branch, branch_ne, regwrite, regdst, memtoreg, alusrca, alusrcb, signext,
                shamtsrc, pcsrc, alucontrol, mif.readcontrol, mif.writecontrol};

  // Hand-written expected vectors, one per controller state.
  function automatic ctl_t z(input logic [3:0] s);
    ctl_t e = '0;
    e.st = s;
    return e;
  endfunction
  function automatic ctl_t fetch(input logic mr);
    ctl_t e = z(ST_FETCH);
    e.memreq = 1'b1; e.alusrcb = 2'b01; e.irwrite = mr; e.pcwrite = mr;
    return e;
  endfunction
  function automatic ctl_t decode();
    ctl_t e = z(ST_DECODE);
    e.alusrcb = 2'b11; e.signext = 1'b1;
    return e;
  endfunction
  function automatic ctl_t memadr();
    ctl_t e = z(ST_MEMADR);
    e.alusrca = 1'b1; e.alusrcb = 2'b10; e.signext = 1'b1;
    return e;
  endfunction
  function automatic ctl_t memrd(input logic [2:0] rc);
    ctl_t e = z(ST_MEMRD);
    e.memreq = 1'b1; e.iord = 1'b1; e.rc = rc;
    return e;
  endfunction
  function automatic ctl_t memwb();
    ctl_t e = z(ST_MEMWB);
    e.regwrite = 1'b1; e.memtoreg = 2'b01;
    return e;
  endfunction
  function automatic ctl_t memwr(input logic [1:0] wc);
    ctl_t e = z(ST_MEMWR);
    e.memreq = 1'b1; e.memwrite = 1'b1; e.iord = 1'b1; e.wc = wc;
    return e;
  endfunction
  function automatic ctl_t exec(input logic [4:0] alu, input logic sh);
    ctl_t e = z(ST_EXEC);
    e.alusrca = 1'b1; e.alu = alu; e.shamtsrc = sh;
    return e;
  endfunction
  function automatic ctl_t aluwb();
    ctl_t e = z(ST_ALUWB);
    e.regwrite = 1'b1; e.regdst = 2'b01;
    return e;
  endfunction
  function automatic ctl_t execi(input logic [4:0] alu, input logic se);
    ctl_t e = z(ST_EXECI);
    e.alusrca = 1'b1; e.alusrcb = 2'b10; e.signext = se; e.alu = alu;
    return e;
  endfunction
  function automatic ctl_t aluiwb();
    ctl_t e = z(ST_ALUIWB);
    e.regwrite = 1'b1;
    return e;
  endfunction
  function automatic ctl_t br(input logic ne);
    ctl_t e = z(ST_BRANCH);
    e.alusrca = 1'b1; e.alu = 5'd1; e.branch = 1'b1; e.branch_ne = ne; e.pcsrc = 2'b01;
    return e;
  endfunction
  function automatic ctl_t jal();
    ctl_t e = z(ST_JAL);
    e.pcwrite = 1'b1; e.pcsrc = 2'b10; e.regwrite = 1'b1; e.regdst = 2'b10; e.memtoreg = 2'b10;
    return e;
  endfunction
  function automatic ctl_t jr();
    ctl_t e = z(ST_JR);
    e.pcwrite = 1'b1; e.pcsrc = 2'b11;
    return e;
  endfunction
  function automatic ctl_t flt();
    ctl_t e = z(ST_FAULT);
    e.fault = 1'b1;
    return e;
  endfunction

  task automatic step(input logic r, input logic mr, input logic [5:0] o, input logic [5:0] f,
                      input string nm, input ctl_t e);
    sb_t item;
    @(posedge clk);
    #1;
    reset = r; mif.mem_ready = mr; op = o; funct = f;
    item.cyc = cyc; item.name = nm; item.exp = e;
    sb.push_back(item);
  endtask

  // Monitor: compare every queued expectation that belongs to the current cycle.
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      sb_t it;
      it = sb.pop_front();
      n_cmp++;
      if (act !== it.exp) begin
        n_bad++;
        $display("FAIL %s cyc=%0d state got %0d want %0d ctl got %h want %h",
                 it.name, it.cyc, act.st, it.exp.st, act, it.exp);
      end
    end
  end

  initial begin
    reset = 1'b0; start = 1'b0; zero = 1'b0; op = '0; funct = '0; mif.mem_ready = 1'b0;

    step(0, 0, 6'h00, 6'h20, "rst_state0", z(ST_FETCH));
    step(0, 1, 6'h00, 6'h20, "rst_state1", z(ST_FETCH));

    // add $3,$1,$2
    step(1, 1, 6'h00, 6'h20, "add_fetch",  fetch(1));
    step(1, 0, 6'h00, 6'h20, "add_decode", decode());
    step(1, 0, 6'h00, 6'h20, "add_exec",   exec(5'd0, 0));
    step(1, 0, 6'h00, 6'h20, "add_wb",     aluwb());

    // lw with three not-ready cycles in MEMRD
    step(1, 1, 6'h23, 6'h00, "lw_fetch",  fetch(1));
    step(1, 0, 6'h23, 6'h00, "lw_decode", decode());
    step(1, 0, 6'h23, 6'h00, "lw_memadr", memadr());
    for (int i = 0; i < 3; i++) step(1, 0, 6'h23, 6'h00, "lw_memrd_wait", memrd(3'b000));
    step(1, 1, 6'h23, 6'h00, "lw_memrd_done", memrd(3'b000));
    step(1, 0, 6'h23, 6'h00, "lw_memwb", memwb());

    // sb then lhu
    step(1, 1, 6'h28, 6'h00, "sb_fetch",  fetch(1));
    step(1, 0, 6'h28, 6'h00, "sb_decode", decode());
    step(1, 0, 6'h28, 6'h00, "sb_memadr", memadr());
    step(1, 1, 6'h28, 6'h00, "sb_memwr",  memwr(2'b10));
    step(1, 1, 6'h25, 6'h00, "lhu_fetch",  fetch(1));
    step(1, 0, 6'h25, 6'h00, "lhu_decode", decode());
    step(1, 0, 6'h25, 6'h00, "lhu_memadr", memadr());
    step(1, 1, 6'h25, 6'h00, "lhu_memrd",  memrd(3'b010));
    step(1, 0, 6'h25, 6'h00, "lhu_memwb",  memwb());

    // branches and jumps
    step(1, 1, 6'h05, 6'h00, "bne_fetch",  fetch(1));
    step(1, 0, 6'h05, 6'h00, "bne_decode", decode());
    step(1, 0, 6'h05, 6'h00, "bne_branch", br(1));
    step(1, 1, 6'h04, 6'h00, "beq_fetch",  fetch(1));
    step(1, 0, 6'h04, 6'h00, "beq_decode", decode());
    step(1, 0, 6'h04, 6'h00, "beq_branch", br(0));
    step(1, 1, 6'h03, 6'h00, "jal_fetch",  fetch(1));
    step(1, 0, 6'h03, 6'h00, "jal_decode", decode());
    step(1, 0, 6'h03, 6'h00, "jal_exec",   jal());
    step(1, 1, 6'h00, 6'h08, "jr_fetch",   fetch(1));
    step(1, 0, 6'h00, 6'h08, "jr_decode",  decode());
    step(1, 0, 6'h00, 6'h08, "jr_exec",    jr());

    // immediates and shifts
    step(1, 1, 6'h0D, 6'h00, "ori_fetch",  fetch(1));
    step(1, 0, 6'h0D, 6'h00, "ori_decode", decode());
    step(1, 0, 6'h0D, 6'h00, "ori_execi",  execi(5'd3, 0));
    step(1, 0, 6'h0D, 6'h00, "ori_wb",     aluiwb());
    step(1, 1, 6'h0A, 6'h00, "slti_fetch", fetch(1));
    step(1, 0, 6'h0A, 6'h00, "slti_decode", decode());
    step(1, 0, 6'h0A, 6'h00, "slti_execi", execi(5'd6, 1));
    step(1, 0, 6'h0A, 6'h00, "slti_wb",    aluiwb());
    step(1, 1, 6'h00, 6'h00, "sll_fetch",  fetch(1));
    step(1, 0, 6'h00, 6'h00, "sll_decode", decode());
    step(1, 0, 6'h00, 6'h00, "sll_exec",   exec(5'd8, 1));
    step(1, 0, 6'h00, 6'h00, "sll_wb",     aluwb());

    // sw: mem_ready arrives exactly on the 16th wait cycle, access completes
    step(1, 1, 6'h2B, 6'h00, "sw_fetch",  fetch(1));
    step(1, 0, 6'h2B, 6'h00, "sw_decode", decode());
    step(1, 0, 6'h2B, 6'h00, "sw_memadr", memadr());
    for (int i = 0; i < 15; i++) step(1, 0, 6'h2B, 6'h00, "sw_memwr_wait", memwr(2'b00));
    step(1, 1, 6'h2B, 6'h00, "sw_memwr_limit", memwr(2'b00));

    // lw interrupted by reset while the read is outstanding
    step(1, 1, 6'h23, 6'h00, "lw2_fetch",  fetch(1));
    step(1, 0, 6'h23, 6'h00, "lw2_decode", decode());
    step(1, 0, 6'h23, 6'h00, "lw2_memadr", memadr());
    step(1, 0, 6'h23, 6'h00, "lw2_memrd",  memrd(3'b000));
    step(0, 1, 6'h23, 6'h00, "rst_mid_access", z(ST_FETCH));
    step(0, 1, 6'h23, 6'h00, "rst_mid_hold",   z(ST_FETCH));

    // fetch timeout: 16 not-ready cycles then FAULT, absorbing
    for (int i = 0; i < 16; i++) step(1, 0, 6'h00, 6'h20, "fetch_wait", fetch(0));
    step(1, 0, 6'h00, 6'h20, "fetch_timeout", flt());
    start = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 1, 6'h00, 6'h20, "fault_sticky", flt());
    start = 1'b0;
    step(0, 1, 6'h00, 6'h20, "rst_from_fault", z(ST_FETCH));

    // illegal opcode and unknown R-type funct
    step(1, 1, 6'h3F, 6'h00, "ill_fetch",  fetch(1));
    step(1, 0, 6'h3F, 6'h00, "ill_decode", decode());
    step(1, 0, 6'h3F, 6'h00, "ill_fault",  flt());
    step(0, 0, 6'h3F, 6'h00, "ill_reset",  z(ST_FETCH));
    step(1, 1, 6'h00, 6'h01, "badfn_fetch",  fetch(1));
    step(1, 0, 6'h00, 6'h01, "badfn_decode", decode());
    step(1, 0, 6'h00, 6'h01, "badfn_fault",  flt());

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain left %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Multicycle successor to the single-cycle MIPS controller: one FSM sequences fetch, decode, execute, memory and writeback over several cycles.
- Sits beside a multicycle datapath inside the mips top and drives every datapath and memory control line per state.
- Adds a memory request/ready handshake with a bounded wait, a parametrised ALU/memory control width, and a fault state for illegal opcodes and memory timeouts.

Parameters:
- ALUCTRL_W, 5, width of alucontrol.
- MEM_TIMEOUT, 16, maximum cycles a memory access may wait on mem_ready before fault; must be 1..255.
- RESET_TO_FETCH, 1, when 1 leave reset in FETCH; when 0 leave reset in IDLE until start.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE (used only when RESET_TO_FETCH=0).
- op  in  6  instr[31:26] from instruction register.
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory accepted or completed the current access.
- memreq  out  1  memory access request.
- memwrite  out  1  store access.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- irwrite  out  1  load instruction register.
- pcwrite  out  1  unconditional PC write.
- branch  out  1  conditional PC write.
- branch_ne  out  1  condition is !zero (bne) instead of zero.
- regwrite  out  1  register file write.
- regdst  out  2  00 rt, 01 rd, 10 $31.
- memtoreg  out  2  00 ALUOut, 01 MDR, 10 PC.
- alusrca  out  1  0 PC, 1 rs.
- alusrcb  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2.
- signext  out  1  1 sign-extend imm, 0 zero-extend.
- shamtsrc  out  1  ALU A = shamt.
- pcsrc  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 rs.
- alucontrol  out  ALUCTRL_W  ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLTU 7, SLL 8, SRL 9, SRA 10, LUI 11.
- readcontrol  out  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu.
- writecontrol  out  2  00 sw, 01 sh, 10 sb.
- fault  out  1  sticky fault indication.
- state_dbg  out  4  current state encoding.

Behaviour:
- Control outputs are combinational from the registered state, plus op/funct in decode-dependent states.
- Every output is 0 in IDLE and in FAULT.
- Reset: state = FETCH (or IDLE), wait counter = 0, fault = 0.
- FETCH: memreq=1, iord=0, alusrca=0, alusrcb=01, ADD, pcsrc=00.
  - irwrite and pcwrite assert only in the cycle mem_ready=1; that cycle the FSM goes to DECODE.
  - Otherwise hold in FETCH.
- DECODE: alusrca=0, alusrcb=11, signext=1, ADD (branch target to ALUOut). Next state by op:
  - lw/lh/lhu/lb/lbu/sw/sh/sb -> MEMADR.
  - R-type (op 0) -> JR if funct=08, else EXEC.
  - addi/andi/ori/xori/slti/sltiu/lui -> EXECI.
  - beq/bne -> BRANCH.
  - j -> JUMP; jal -> JAL.
  - Any other op, or an unknown R-type funct, -> FAULT.
- MEMADR: alusrca=1, alusrcb=10, signext=1, ADD -> MEMRD for loads, MEMWR for stores.
- MEMRD: memreq=1, iord=1, readcontrol per op; wait for mem_ready -> MEMWB.
- MEMWB: regwrite=1, regdst=00, memtoreg=01 -> FETCH.
- MEMWR: memreq=1, memwrite=1, iord=1, writecontrol per op; on mem_ready -> FETCH.
- EXEC: alusrca=1, alusrcb=00, ALU op from funct; sll/srl/sra set shamtsrc=1 -> ALUWB.
- ALUWB: regwrite, regdst=01, memtoreg=00 -> FETCH.
- EXECI: alusrca=1, alusrcb=10.
  - signext=0 for andi/ori/xori/lui, else 1.
  - slti -> SLT, sltiu -> SLTU.
  - -> ALUIWB (regwrite, regdst=00) -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, SUB, branch=1, branch_ne=(op==bne), pcsrc=01 -> FETCH.
- JUMP: pcwrite, pcsrc=10 -> FETCH.
- JAL: pcwrite, pcsrc=10, regwrite, regdst=10, memtoreg=10 -> FETCH.
- JR: pcwrite, pcsrc=11 -> FETCH.
- Wait counter (FETCH, MEMRD, MEMWR):
  - Clears on entry to each of these states and on mem_ready.
  - Increments each cycle mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0 -> FAULT.
  - mem_ready in the same cycle the count hits the limit wins; the access completes.
- FAULT is absorbing: fault=1 and all controls 0 until reset. start is ignored there.
- Asynchronous reset mid-access drops memreq immediately. No partial regwrite or pcwrite can occur after reset asserts.
- CPI: R-type/I-type 4, lw 5, sw 4, branch 3, j/jal/jr 3, each with zero memory wait; add wait cycles per access.

Test Plan:
- add $3,$1,$2 (op 0, funct 20), mem_ready always 1 -> states FETCH, DECODE, EXEC, ALUWB, FETCH.
  - alucontrol=0 in EXEC; regwrite=1 with regdst=01 for exactly one cycle.
- lw with mem_ready low for 3 cycles in MEMRD -> memreq held 4 cycles, readcontrol=000; MEMWB regwrite=1, memtoreg=01; total 8 cycles.
- sb then lhu -> writecontrol=10 with memwrite=1 in MEMWR; readcontrol=010 in MEMRD; signext=1 in MEMADR.
- bne in BRANCH -> branch=1, branch_ne=1, alucontrol=1. jal -> regdst=10, memtoreg=10, pcsrc=10, pcwrite=1.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=16 -> fault=1 after 16 wait cycles.
  - Outputs then stay 0; async reset low -> state_dbg shows FETCH, fault=0.
- Illegal op 0x3F -> DECODE then FAULT.
  - ori -> signext=0, alucontrol=3.
  - sll -> shamtsrc=1, alucontrol=8.
